// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32I five-stage core: captures the decoded bundle,
// inserts bubbles on load-use and redirect, drives IF/ID stall/flush, counts bubbles.
module id_ex_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              RegWriteD,
  input  logic              ALUSrcD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic [1:0]        ResultSrcD,
  input  logic [1:0]        MemOpD,
  input  logic [3:0]        ALUControlD,
  input  logic [2:0]        funct3D,
  input  logic [XLEN-1:0]   RD1D,
  input  logic [XLEN-1:0]   RD2D,
  input  logic [XLEN-1:0]   ImmExtD,
  input  logic [XLEN-1:0]   PCD,
  input  logic [XLEN-1:0]   PCPlus4D,
  input  logic [4:0]        Rs1D,
  input  logic [4:0]        Rs2D,
  input  logic [4:0]        RdD,
  input  logic              PCSrcE,
  output logic              RegWriteE,
  output logic              ALUSrcE,
  output logic              MemWriteE,
  output logic              BranchE,
  output logic              JumpE,
  output logic [1:0]        ResultSrcE,
  output logic [1:0]        MemOpE,
  output logic [3:0]        ALUControlE,
  output logic [2:0]        funct3E,
  output logic [XLEN-1:0]   RD1E,
  output logic [XLEN-1:0]   RD2E,
  output logic [XLEN-1:0]   ImmExtE,
  output logic [XLEN-1:0]   PCE,
  output logic [XLEN-1:0]   PCPlus4E,
  output logic [4:0]        Rs1E,
  output logic [4:0]        Rs2E,
  output logic [4:0]        RdE,
  output logic              ValidE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic [CNT_W-1:0]  BubbleCnt
);

  localparam logic [1:0] RES_LOAD = 2'b01;

  typedef struct packed {
    logic            reg_write;
    logic            alu_src;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [1:0]      result_src;
    logic [1:0]      mem_op;
    logic [3:0]      alu_control;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm_ext;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
  } id_ex_t;

  id_ex_t           ex_d, ex_q;
  logic             valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             lw_stall;
  logic             flush_e;

  // Hazard detection and next-state of the EX register and bubble counter
  always_comb begin
    lw_stall = valid_q && (ex_q.result_src == RES_LOAD) && (ex_q.rd != 5'd0) &&
               ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D));
    flush_e  = lw_stall || PCSrcE;
    ex_d     = '0;
    valid_d  = 1'b0;
    cnt_d    = cnt_q;
    if (!flush_e) begin
      ex_d.reg_write   = RegWriteD;
      ex_d.alu_src     = ALUSrcD;
      ex_d.mem_write   = MemWriteD;
      ex_d.branch      = BranchD;
      ex_d.jump        = JumpD;
      ex_d.result_src  = ResultSrcD;
      ex_d.mem_op      = MemOpD;
      ex_d.alu_control = ALUControlD;
      ex_d.funct3      = funct3D;
      ex_d.rd1         = RD1D;
      ex_d.rd2         = RD2D;
      ex_d.imm_ext     = ImmExtD;
      ex_d.pc          = PCD;
      ex_d.pc_plus4    = PCPlus4D;
      ex_d.rs1         = Rs1D;
      ex_d.rs2         = Rs2D;
      ex_d.rd          = RdD;
      valid_d          = 1'b1;
    end
    // Counter saturates at all-ones; a redirect does not suppress the count
    if (lw_stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  // A redirect overrides the stall so the PC can take the branch target
  assign StallF = lw_stall & ~PCSrcE;
  assign StallD = lw_stall & ~PCSrcE;
  assign FlushD = PCSrcE;

  assign RegWriteE   = ex_q.reg_write;
  assign ALUSrcE     = ex_q.alu_src;
  assign MemWriteE   = ex_q.mem_write;
  assign BranchE     = ex_q.branch;
  assign JumpE       = ex_q.jump;
  assign ResultSrcE  = ex_q.result_src;
  assign MemOpE      = ex_q.mem_op;
  assign ALUControlE = ex_q.alu_control;
  assign funct3E     = ex_q.funct3;
  assign RD1E        = ex_q.rd1;
  assign RD2E        = ex_q.rd2;
  assign ImmExtE     = ex_q.imm_ext;
  assign PCE         = ex_q.pc;
  assign PCPlus4E    = ex_q.pc_plus4;
  assign Rs1E        = ex_q.rs1;
  assign Rs2E        = ex_q.rs2;
  assign RdE         = ex_q.rd;
  assign ValidE      = valid_q;
  assign BubbleCnt   = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: vector table for passthrough/hazard/redirect cases,
// plus hand sequences for reset, counter saturation (CNT_W = 4) and async reset.
module tb_id_ex_stage;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD;
  logic [1:0] ResultSrcD, MemOpD;
  logic [3:0] ALUControlD;
  logic [2:0] funct3D;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0] Rs1D, Rs2D, RdD;
  logic PCSrcE;
  logic RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE;
  logic [1:0] ResultSrcE, MemOpE;
  logic [3:0] ALUControlE;
  logic [2:0] funct3E;
  logic [XLEN-1:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0] Rs1E, Rs2E, RdE;
  logic ValidE, StallF, StallD, FlushD;
  logic [CNT_W-1:0] BubbleCnt;

  id_ex_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .RegWriteD(RegWriteD), .ALUSrcD(ALUSrcD), .MemWriteD(MemWriteD), .BranchD(BranchD),
    .JumpD(JumpD), .ResultSrcD(ResultSrcD), .MemOpD(MemOpD), .ALUControlD(ALUControlD),
    .funct3D(funct3D), .RD1D(RD1D), .RD2D(RD2D), .ImmExtD(ImmExtD), .PCD(PCD),
    .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD), .PCSrcE(PCSrcE),
    .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE), .BranchE(BranchE),
    .JumpE(JumpE), .ResultSrcE(ResultSrcE), .MemOpE(MemOpE), .ALUControlE(ALUControlE),
    .funct3E(funct3E), .RD1E(RD1E), .RD2E(RD2E), .ImmExtE(ImmExtE), .PCE(PCE),
    .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE), .ValidE(ValidE),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .BubbleCnt(BubbleCnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw, asrc, mw, br, jp;
    logic [1:0]  rsrc, mop;
    logic [3:0]  alu;
    logic [2:0]  f3;
    logic [31:0] rd1, rd2, imm, pc, pc4;
    logic [4:0]  rs1, rs2, rd;
    logic        pcsrc;
    logic        x_stall, x_flushd, x_bub, x_valid;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int exp_cnt  = 0;
  localparam int NV = 15;
  vec_t vecs [NV];

  function automatic vec_t mk(input int idx, input logic [4:0] ctl, input logic [1:0] rsrc,
                              input logic [1:0] mop, input logic [3:0] alu, input logic [2:0] f3,
                              input logic [31:0] imm, input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic pcsrc, input logic [3:0] x);
    vec_t v;
    {v.rw, v.asrc, v.mw, v.br, v.jp} = ctl;
    v.rsrc = rsrc; v.mop = mop; v.alu = alu; v.f3 = f3; v.imm = imm;
    v.rd1 = 32'hA000_0000 + 32'(idx);
    v.rd2 = 32'hB000_0100 + 32'(idx);
    v.pc  = 32'h0000_1000 + 32'(idx * 4);
    v.pc4 = 32'h0000_1004 + 32'(idx * 4);
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.pcsrc = pcsrc;
    {v.x_stall, v.x_flushd, v.x_bub, v.x_valid} = x;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    {RegWriteD, ALUSrcD, MemWriteD, BranchD, JumpD} = {v.rw, v.asrc, v.mw, v.br, v.jp};
    ResultSrcD = v.rsrc; MemOpD = v.mop; ALUControlD = v.alu; funct3D = v.f3;
    RD1D = v.rd1; RD2D = v.rd2; ImmExtD = v.imm; PCD = v.pc; PCPlus4D = v.pc4;
    Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd; PCSrcE = v.pcsrc;
  endtask

  // Compare every EX output against the vector (valid) or all zeros (bubble)
  task automatic check_e(input string t, input vec_t v, input logic valid);
    vec_t z;
    z = v;
    if (!valid) begin
      {z.rw, z.asrc, z.mw, z.br, z.jp} = 5'b0;
      z.rsrc = '0; z.mop = '0; z.alu = '0; z.f3 = '0;
      z.rd1 = '0; z.rd2 = '0; z.imm = '0; z.pc = '0; z.pc4 = '0;
      z.rs1 = '0; z.rs2 = '0; z.rd = '0;
    end
    chk({t, " ctl"}, 32'({RegWriteE, ALUSrcE, MemWriteE, BranchE, JumpE}),
        32'({z.rw, z.asrc, z.mw, z.br, z.jp}));
    chk({t, " ResultSrcE"}, 32'(ResultSrcE), 32'(z.rsrc));
    chk({t, " MemOpE"}, 32'(MemOpE), 32'(z.mop));
    chk({t, " ALUControlE"}, 32'(ALUControlE), 32'(z.alu));
    chk({t, " funct3E"}, 32'(funct3E), 32'(z.f3));
    chk({t, " RD1E"}, RD1E, z.rd1);
    chk({t, " RD2E"}, RD2E, z.rd2);
    chk({t, " ImmExtE"}, ImmExtE, z.imm);
    chk({t, " PCE"}, PCE, z.pc);
    chk({t, " PCPlus4E"}, PCPlus4E, z.pc4);
    chk({t, " regs"}, 32'({Rs1E, Rs2E, RdE}), 32'({z.rs1, z.rs2, z.rd}));
    chk({t, " ValidE"}, 32'(ValidE), 32'(valid));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t v;
    logic [CNT_W-1:0] prev;
    vecs[0]  = mk(0,  5'b10000, 2'b00, 2'b00, 4'b0010, 3'b000, 32'h10, 5'd1, 5'd2, 5'd5, 1'b0, 4'b0001);
    vecs[1]  = mk(1,  5'b11000, 2'b01, 2'b10, 4'b0000, 3'b010, 32'h4, 5'd5, 5'd0, 5'd7, 1'b0, 4'b0001);
    vecs[2]  = mk(2,  5'b10000, 2'b00, 2'b00, 4'b0000, 3'b000, 32'h0, 5'd7, 5'd3, 5'd8, 1'b0, 4'b1010);
    vecs[3]  = mk(2,  5'b10000, 2'b00, 2'b00, 4'b0000, 3'b000, 32'h0, 5'd7, 5'd3, 5'd8, 1'b0, 4'b0001);
    vecs[4]  = mk(4,  5'b11000, 2'b01, 2'b01, 4'b0000, 3'b100, 32'h8, 5'd9, 5'd0, 5'd0, 1'b0, 4'b0001);
    vecs[5]  = mk(5,  5'b10000, 2'b00, 2'b00, 4'b0110, 3'b000, 32'h0, 5'd0, 5'd0, 5'd10, 1'b0, 4'b0001);
    vecs[6]  = mk(6,  5'b11000, 2'b01, 2'b10, 4'b0000, 3'b010, 32'hC, 5'd1, 5'd0, 5'd12, 1'b0, 4'b0001);
    vecs[7]  = mk(7,  5'b10000, 2'b00, 2'b00, 4'b0001, 3'b001, 32'h0, 5'd12, 5'd12, 5'd13, 1'b0, 4'b1010);
    vecs[8]  = mk(7,  5'b10000, 2'b00, 2'b00, 4'b0001, 3'b001, 32'h0, 5'd12, 5'd12, 5'd13, 1'b0, 4'b0001);
    vecs[9]  = mk(9,  5'b11000, 2'b01, 2'b10, 4'b0000, 3'b010, 32'h0, 5'd2, 5'd0, 5'd14, 1'b1, 4'b0100);
    vecs[10] = mk(10, 5'b10000, 2'b00, 2'b00, 4'b0111, 3'b111, 32'hFFFF_FFF0, 5'd14, 5'd3, 5'd15, 1'b0, 4'b0001);
    vecs[11] = mk(11, 5'b11000, 2'b01, 2'b00, 4'b0000, 3'b000, 32'h0, 5'd15, 5'd0, 5'd16, 1'b0, 4'b0001);
    vecs[12] = mk(12, 5'b10000, 2'b00, 2'b00, 4'b0000, 3'b000, 32'h0, 5'd1, 5'd16, 5'd18, 1'b1, 4'b0110);
    vecs[13] = mk(13, 5'b01111, 2'b10, 2'b11, 4'b1000, 3'b101, 32'h800, 5'd3, 5'd4, 5'd17, 1'b0, 4'b0001);
    vecs[14] = mk(14, 5'b00000, 2'b00, 2'b00, 4'b0101, 3'b000, 32'h0, 5'd17, 5'd17, 5'd19, 1'b0, 4'b0001);

    // Reset held with toggling decode inputs
    rst_n = 1'b0;
    PCSrcE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v = mk(100 + i, 5'($urandom), 2'($urandom), 2'($urandom), 4'($urandom), 3'($urandom),
             $urandom, 5'($urandom), 5'($urandom), 5'($urandom), 1'b0, 4'b0000);
      v.rd1 = $urandom; v.rd2 = $urandom;
      drive(v);
      tick();
      check_e($sformatf("reset%0d", i), v, 1'b0);
      chk("reset BubbleCnt", 32'(BubbleCnt), 32'd0);
      chk("reset stall/flush", 32'({StallF, StallD, FlushD}), 32'd0);
    end
    // Release: first edge loads decode normally
    v.rsrc = 2'b00;
    v.rw = 1'b1;
    drive(v);
    rst_n = 1'b1;
    tick();
    chk("release RegWriteE", 32'(RegWriteE), 32'(v.rw));
    chk("release ValidE", 32'(ValidE), 32'd1);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d StallF", i), 32'(StallF), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d StallD", i), 32'(StallD), 32'(vecs[i].x_stall));
      chk($sformatf("v%0d FlushD", i), 32'(FlushD), 32'(vecs[i].x_flushd));
      tick();
      if (vecs[i].x_bub) exp_cnt = exp_cnt + 1;
      check_e($sformatf("v%0d", i), vecs[i], vecs[i].x_valid);
      chk($sformatf("v%0d BubbleCnt", i), 32'(BubbleCnt), 32'(exp_cnt));
    end

    // Saturation: 20 load-use hazards with a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      v = mk(200, 5'b11000, 2'b01, 2'b10, 4'b0000, 3'b010, 32'h0, 5'd1, 5'd0, 5'd20, 1'b0, 4'b0001);
      drive(v);
      #1;
      chk("sat load StallF", 32'(StallF), 32'd0);
      tick();
      v = mk(201, 5'b10000, 2'b00, 2'b00, 4'b0011, 3'b000, 32'h0, 5'd20, 5'd2, 5'd21, 1'b0, 4'b0001);
      drive(v);
      #1;
      chk("sat dep StallF", 32'(StallF), 32'd1);
      prev = BubbleCnt;
      tick();
      exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
      chk("sat BubbleCnt", 32'(BubbleCnt), 32'(exp_cnt));
      chk("sat no wrap", 32'(BubbleCnt >= prev), 32'd1);
      chk("sat bubble ValidE", 32'(ValidE), 32'd0);
      #1;
      chk("sat replay StallF", 32'(StallF), 32'd0);
      tick();
      chk("sat dep in EX", 32'({ValidE, RdE}), 32'({1'b1, 5'd21}));
    end

    // Asynchronous reset asserted mid-cycle
    #2;
    rst_n = 1'b0;
    #1;
    chk("async ValidE", 32'(ValidE), 32'd0);
    chk("async BubbleCnt", 32'(BubbleCnt), 32'd0);
    chk("async RdE", 32'(RdE), 32'd0);
    chk("async ALUControlE", 32'(ALUControlE), 32'd0);
    chk("async stall/flush", 32'({StallF, StallD, FlushD}), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
